// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Contents: FSM state encoding and the counter-width helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Bit counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin.
// Ports: a, b, bin (in); d, bout (out).
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    assign o_d    = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first, one bit/clock.
// Ports: clk, rst_n, start, a, b (in); busy, done, diff, bout, ovf (out).
// Option: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sd;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic             r_brw;
    logic             r_done;
    logic             r_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_ovf;
`endif

    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_sd_next;

    full_subtractor u_fs (
        .i_a    (r_sa[0]),
        .i_b    (r_sb[0]),
        .i_bin  (r_brw),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // New difference bit enters at the MSB; after WIDTH shifts
    // the word is aligned.
    generate
        if (WIDTH == 1) begin : g_sd_1
            assign w_sd_next = w_d;
        end else begin : g_sd_n
            assign w_sd_next = {w_d, r_sd[WIDTH-1:1]};
        end
    endgenerate

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_sd    <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_brw   <= 1'b0;
            r_done  <= 1'b0;
            r_bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_sd    <= '0;
                        r_cnt   <= '0;
                        r_brw   <= 1'b0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_sd  <= w_sd_next;
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_brw <= w_bout;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_diff  <= w_sd_next;
                        r_bout  <= w_bout;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
                        // r_brw here is the borrow into the MSB.
                        r_ovf   <= r_brw ^ w_bout;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state == S_SHIFT);
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule
